// File: rtl/eth_fifo_pkg.sv
// Shared definitions for the Ethernet TX FIFO write path: word layout and
// the frame arbiter state encoding.
package eth_fifo_pkg;

  localparam int FIFO_W  = 9;
  localparam int EOF_BIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/tx_rr_pick.sv
// Rotating-priority picker: returns the first asserted request at or above
// ptr, wrapping around, so the most recent winner drops to lowest priority.
module tx_rr_pick
  import eth_fifo_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_SRC)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_SRC);

  // Walk from the farthest offset down, so the nearest request overwrites last.
  always_comb begin
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_SRC;
      if (req[j]) begin
        any = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Write-side controller for the shared 9-bit Ethernet TX FIFO: round-robin,
// frame-atomic arbitration between byte-stream sources with length truncation.
module tx_frame_arbiter
  import eth_fifo_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [8*NUM_SRC-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [FIFO_W-1:0]          fifo_di,
  output logic                       fifo_we,
  input  logic                       fifo_full,
  input  logic                       fifo_afull,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic [CNT_W-1:0]           trunc_cnt
);

  localparam int IDX_W = $clog2(NUM_SRC);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [LEN_W-1:0] byte_cnt;
  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;
  logic             trunc;
  logic             accept;

  tx_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req (src_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    g_valid  = src_valid[grant_id];
    g_last   = src_last[grant_id];
    g_data   = src_data[8*grant_id +: 8];
    trunc    = (byte_cnt == LEN_W'(MAX_LEN - 1));
    accept   = (state == STREAM) && g_valid && !fifo_full;
    next_ptr = (grant_id == IDX_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
  end

  // Datapath outputs follow the inputs combinationally so a byte is written
  // in the same cycle the source offers it.
  always_comb begin
    src_ready = '0;
    fifo_we   = 1'b0;
    fifo_di   = '0;
    busy      = (state != IDLE);
    case (state)
      STREAM: begin
        src_ready[grant_id] = !fifo_full;
        fifo_we             = accept;
        fifo_di[7:0]        = g_data;
        fifo_di[EOF_BIT]    = g_last | trunc;
      end
      DRAIN:   src_ready[grant_id] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      byte_cnt  <= '0;
      frame_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Only start a frame when the FIFO has room for a burst.
          if (!fifo_afull && pick_any) begin
            grant_id <= pick_idx;
            byte_cnt <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (g_last) begin
              frame_cnt <= frame_cnt + 1'b1;
              rr_ptr    <= next_ptr;
              state     <= IDLE;
            end else if (trunc) begin
              frame_cnt <= frame_cnt + 1'b1;
              trunc_cnt <= trunc_cnt + 1'b1;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (g_valid && g_last) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Randomized scoreboard bench for tx_frame_arbiter: per-source frame queues
// plus a round-robin grant predictor, checked by an independent monitor.
module tb_tx_frame_arbiter;

  localparam int NUM_SRC = 4;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = $clog2(NUM_SRC);
  localparam int MAXF    = 12;
  localparam int NFR     = 8;
  localparam int TMO     = 3000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic [8:0]           fifo_di;
  logic                 fifo_we;
  logic                 fifo_full;
  logic                 fifo_afull;
  logic [IDX_W-1:0]     grant_id;
  logic                 busy;
  logic [CNT_W-1:0]     frame_cnt;
  logic [CNT_W-1:0]     trunc_cnt;

  logic       drv_valid [NUM_SRC];
  logic [7:0] drv_data  [NUM_SRC];
  logic       drv_last  [NUM_SRC];

  logic [8:0] exp_q [NUM_SRC][$];
  int         grant_q [$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         exp_frames = 0;
  int         exp_trunc = 0;
  int         done_cnt = 0;
  bit         run_go = 0;
  bit         mon_en = 0;
  bit         rand_en = 0;
  int         model_ptr = 0;
  int         cur_src = 0;
  bit         in_frame = 0;

  always #5 clk = ~clk;

  tx_frame_arbiter #(
    .NUM_SRC (NUM_SRC),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_last   (src_last),
    .src_ready  (src_ready),
    .fifo_di    (fifo_di),
    .fifo_we    (fifo_we),
    .fifo_full  (fifo_full),
    .fifo_afull (fifo_afull),
    .grant_id   (grant_id),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .trunc_cnt  (trunc_cnt)
  );

  always_comb begin
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_valid[i]      = drv_valid[i];
      src_data[8*i +: 8] = drv_data[i];
      src_last[i]       = drv_last[i];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagTimeout(input string name);
    n_vec++;
    n_bad++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int modelPick(input int ptr, input logic [NUM_SRC-1:0] vec);
    for (int k = 0; k < NUM_SRC; k++)
      if (vec[(ptr + k) % NUM_SRC]) return (ptr + k) % NUM_SRC;
    return -1;
  endfunction

  task automatic pushExpected(input int s, input int len, input logic [7:0] fb [MAXF]);
    for (int k = 0; k < len && k < MAX_LEN; k++)
      exp_q[s].push_back({(k == len - 1) || (k == MAX_LEN - 1), fb[k]});
    exp_frames++;
    if (len > MAX_LEN) exp_trunc++;
  endtask

  task automatic applyStimulus(input int s, input int len, input logic [7:0] fb [MAXF]);
    for (int k = 0; k < len; k++) begin
      int t;
      repeat (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0) begin
        @(posedge clk); #1;
      end
      drv_valid[s] = 1'b1;
      drv_data[s]  = fb[k];
      drv_last[s]  = (k == len - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!src_ready[s] && t < TMO);
      if (!src_ready[s]) flagTimeout("handshake");
      @(posedge clk); #1;
      drv_valid[s] = 1'b0;
      drv_last[s]  = 1'b0;
    end
  endtask

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    initial begin : drive
      logic [7:0] fb [MAXF];
      int len;
      drv_valid[s] = 1'b0;
      drv_data[s]  = '0;
      drv_last[s]  = 1'b0;
      wait (run_go);
      for (int f = 0; f < NFR; f++) begin
        for (int k = 0; k < MAXF; k++) fb[k] = 8'($urandom);
        if (s == 0 && f == 0) begin
          len = 3;
          fb[0] = 8'hAA;
          fb[1] = 8'hBB;
          fb[2] = 8'hCC;
        end else begin
          len = int'($urandom_range(1, MAXF));
        end
        pushExpected(s, len, fb);
        applyStimulus(s, len, fb);
        repeat ($urandom_range(0, 4)) begin
          @(posedge clk); #1;
        end
      end
      done_cnt++;
    end
  end

  // FIFO flag pressure: short random bursts of full and almost-full.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) begin
        fifo_full  = ($urandom_range(0, 7) == 0);
        fifo_afull = ($urandom_range(0, 5) == 0);
      end
    end
  end

  // Monitor: predicts grants in idle cycles and checks every FIFO write.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!busy && !fifo_afull && src_valid != '0)
          grant_q.push_back(modelPick(model_ptr, src_valid));
        if (fifo_full) checkOutput("we_while_full", 32'(fifo_we), 32'd0);
        if (fifo_we) begin
          if (!in_frame) begin
            if (grant_q.size() == 0) begin
              flagTimeout("unpredicted_grant");
            end else begin
              cur_src = grant_q.pop_front();
              checkOutput("grant_id", 32'(grant_id), 32'(cur_src));
            end
            in_frame = 1;
          end
          if (exp_q[cur_src].size() == 0) begin
            flagTimeout("extra_write");
          end else begin
            checkOutput("fifo_di", 32'(fifo_di), 32'(exp_q[cur_src].pop_front()));
          end
          if (fifo_di[8]) begin
            in_frame  = 0;
            model_ptr = (cur_src + 1) % NUM_SRC;
          end
        end
      end
    end
  end

  initial begin
    int t;
    int w;
    rst_n      = 1'b0;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_fifo_we", 32'(fifo_we), 32'd0);
    checkOutput("rst_src_ready", 32'(src_ready), 32'd0);
    checkOutput("rst_fifo_di", 32'(fifo_di), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_trunc_cnt", 32'(trunc_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Abandon a frame from source 1 with a one-cycle reset at its second byte.
    drv_valid[1] = 1'b1;
    drv_data[1]  = 8'h11;
    drv_last[1]  = 1'b0;
    t = 0;
    w = 0;
    while (w < 2 && t < 50) begin
      @(negedge clk);
      t++;
      if (fifo_we) w++;
    end
    if (w < 2) flagTimeout("mid_frame_write");
    checkOutput("mid_busy", 32'(busy), 32'd1);
    checkOutput("mid_grant_id", 32'(grant_id), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n        = 1'b1;
    drv_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("rst2_fifo_we", 32'(fifo_we), 32'd0);
    checkOutput("rst2_src_ready", 32'(src_ready), 32'd0);
    checkOutput("rst2_fifo_di", 32'(fifo_di), 32'd0);
    checkOutput("rst2_busy", 32'(busy), 32'd0);
    checkOutput("rst2_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst2_frame_cnt", 32'(frame_cnt), 32'd0);

    @(posedge clk); #1;
    mon_en  = 1;
    rand_en = 1;
    run_go  = 1;
    t = 0;
    while (done_cnt < NUM_SRC && t < 30000) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt < NUM_SRC) flagTimeout("sources_done");
    #1;
    rand_en    = 0;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    repeat (10) @(negedge clk);
    mon_en = 0;
    for (int s = 0; s < NUM_SRC; s++)
      checkOutput("exp_left", 32'(exp_q[s].size()), 32'd0);
    checkOutput("grants_left", 32'(grant_q.size()), 32'd0);
    checkOutput("end_frame_open", 32'(in_frame), 32'd0);
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    checkOutput("trunc_cnt", 32'(trunc_cnt), 32'(exp_trunc));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Write-side controller for the 9-bit Ethernet TX FIFO (bits [7:0] = byte, bit 8 = end-of-frame).
- Shares that single FIFO between NUM_SRC byte-stream frame sources, such as the ARP responder and the UDP builder.
- Arbitration is round-robin and frame-atomic: frames are never interleaved.
- Gates frame starts on almost-full, stalls on full, and enforces a maximum frame length by truncation.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- MAX_LEN, 1518, maximum bytes written per frame.
- LEN_W, 11, width of the per-frame byte counter; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock, same domain as the FIFO write clock.
- rst_n  in  1  synchronous, active-low reset.
- src_valid  in  NUM_SRC  per-source byte valid.
- src_data  in  8*NUM_SRC  per-source byte; source i uses bits [8i+7:8i].
- src_last  in  NUM_SRC  per-source last byte of frame.
- src_ready  out  NUM_SRC  per-source byte accepted when valid&ready.
- fifo_di  out  9  {eof, byte} to the FIFO data input.
- fifo_we  out  1  FIFO write enable.
- fifo_full  in  1  FIFO full flag.
- fifo_afull  in  1  FIFO almost-full flag.
- grant_id  out  $clog2(NUM_SRC)  current or last granted source.
- busy  out  1  high in STREAM or DRAIN.
- frame_cnt  out  CNT_W  frames fully written; wraps at 2^CNT_W.
- trunc_cnt  out  CNT_W  frames truncated; wraps.

Behaviour:
- Reset: synchronous to clk. While rst_n=0 on a rising edge:
  - state<=IDLE; rr_ptr<=0; grant_id<=0; byte_cnt<=0; frame_cnt<=0; trunc_cnt<=0.
  - All outputs read 0: src_ready, fifo_we, fifo_di, busy.
  - Reset mid-frame abandons the frame; no EOF is written. The system asserts FIFO rst in the same window, so a partial frame never reaches the reader.
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - src_ready=0, fifo_we=0.
  - If fifo_afull=0 and any src_valid=1: pick the first valid source searching from rr_ptr upward, with wrap-around. Register grant_id, clear byte_cnt, go to STREAM. This costs one cycle of arbitration latency.
  - If fifo_afull=1, no grant is made, even when requests are pending.
- STREAM (g=grant_id):
  - src_ready[g] = ~fifo_full; all other src_ready bits are 0.
  - fifo_we = src_valid[g] & ~fifo_full.
  - fifo_di = {src_last[g] | trunc, src_data[g]}, where trunc = (byte_cnt == MAX_LEN-1).
  - fifo_we, src_ready and fifo_di are combinational from inputs and state, with zero added latency.
  - fifo_afull is ignored mid-frame; only fifo_full stalls.
  - On each accepted byte, byte_cnt increments.
  - Accepted byte with src_last[g]=1: frame_cnt+1, rr_ptr<=(g+1) mod NUM_SRC, go to IDLE.
  - Accepted byte with trunc=1 and src_last[g]=0: written with eof=1; frame_cnt+1, trunc_cnt+1; go to DRAIN.
  - If src_last and trunc coincide, the byte is treated as a normal last: no trunc_cnt increment.
- DRAIN:
  - src_ready[g]=1, fifo_we=0; source bytes are discarded.
  - On accepted src_last[g]: rr_ptr<=(g+1) mod NUM_SRC, go to IDLE.
- busy=1 in STREAM and DRAIN.
- Back-to-back frames: a minimum of 1 idle cycle between frames (the IDLE arbitration cycle).
- Fairness: a source cannot win two consecutive grants while another source is valid.
- src_valid on non-granted sources is ignored; those sources hold their data (standard valid/ready).

Decomposition:
- Package eth_fifo_pkg holds:
  - FIFO_W=9 and EOF_BIT=8.
  - State enum {IDLE, STREAM, DRAIN}.
- Sub-module tx_rr_pick: combinational rotating-priority picker.
  - Inputs: req[NUM_SRC], ptr.
  - Outputs: any, idx.
  - The top level holds the FSM, counters and muxing.

Test Plan:
- Single source 0, frame AA,BB,CC (last on CC), no full: grant one cycle after valid; fifo_di writes 0x0AA, 0x0BB, 0x1CC on 3 consecutive cycles; frame_cnt=1.
- Sources 0 and 2 valid together, 2-byte frames, rr_ptr=0: source 0's frame is written completely, then source 2's after one IDLE cycle. Repeat with both still valid: source 2 is granted before source 0.
- fifo_afull=1 in IDLE with source 1 valid: no grant and fifo_we=0 for 10 cycles. Deassert afull: grant_id=1 on the next cycle. Afull raised mid-frame: streaming continues.
- fifo_full=1 for 3 cycles mid-frame: src_ready=0 and fifo_we=0 for exactly those cycles; byte order is preserved and no byte is lost or duplicated.
- MAX_LEN=4, 6-byte frame 01..06: writes 0x001, 0x002, 0x003, 0x104. Bytes 05 and 06 are accepted but not written; trunc_cnt=1, frame_cnt=1, back in IDLE.
- rst_n low for one cycle at byte 2 of a frame: all outputs 0 on the next cycle and counters 0. After release, a new frame is arbitrated from rr_ptr=0.
